// File: rtl/pwm_breathe_monitor.sv
// pwm_breathe_monitor
// Samples one PWM LED drive line, measures duty over fixed 2^FRAME_BITS windows
// and tracks the breathe envelope (inhale/exhale), counting trough-to-rise
// reversals as completed breaths. A run of identical windows flags a stall.
module pwm_breathe_monitor #(
    parameter int FRAME_BITS   = 16,
    parameter int HYST         = 2,
    parameter int STALL_FRAMES = 16
) (
    input  logic        Sys_Clk0,
    input  logic        Sys_Clk0_Rst,
    input  logic        en_i,
    input  logic        pwm_i,
    output logic [7:0]  duty_o,
    output logic        duty_valid_o,
    output logic        inhale_o,
    output logic        exhale_o,
    output logic        stalled_o,
    output logic        breath_pulse_o,
    output logic [15:0] breath_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INHALE = 2'd1,
        ST_EXHALE = 2'd2
    } state_t;

    localparam logic [FRAME_BITS-1:0] WIN_LAST = {FRAME_BITS{1'b1}};
    localparam logic [FRAME_BITS-1:0] WIN_ONE  = {{(FRAME_BITS-1){1'b0}}, 1'b1};
    localparam logic [8:0]            HYST9    = HYST[8:0];
    localparam logic [7:0]            STALL_TH = 8'(STALL_FRAMES - 1);

    // Top 8 bits of the high count; a completely high window (2^FRAME_BITS)
    // would otherwise alias to 0, so it clamps to full scale.
    function automatic logic [7:0] sat_duty(input logic [FRAME_BITS:0] h);
        if (h[FRAME_BITS]) begin
            return 8'hFF;
        end
        return h[FRAME_BITS-1 -: 8];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [FRAME_BITS-1:0] win_cnt_q, win_cnt_d;
    logic [FRAME_BITS:0]   high_cnt_q, high_cnt_d;
    logic [7:0]            same_cnt_q, same_cnt_d;
    logic [7:0]            ext_q, ext_d;
    logic                  first_q, first_d;
    state_t                state_q, state_d;
    logic [7:0]            duty_q, duty_d;
    logic                  duty_valid_q, duty_valid_d;
    logic                  stalled_q, stalled_d;
    logic                  breath_pulse_q, breath_pulse_d;
    logic [15:0]           breath_cnt_q, breath_cnt_d;

    logic                  pwm_s;
    logic                  win_end;
    logic [FRAME_BITS:0]   high_final;
    logic [7:0]            duty_new;
    logic                  duty_same;
    logic                  stall_hit;
    logic                  rise;
    logic                  fall;
    logic                  unused_lsbs;

    assign pwm_s       = sync2_q;
    assign unused_lsbs = ^high_final;

    // Two-flop synchronizer for the asynchronous PWM line.
    always_comb begin
        sync1_d = pwm_i;
        sync2_d = sync1_q;
    end

    // Window and high-time counters; the window-end sample is folded into high_final.
    always_comb begin
        high_final = high_cnt_q + {{FRAME_BITS{1'b0}}, pwm_s};
        win_end    = en_i && (win_cnt_q == WIN_LAST);
        win_cnt_d  = win_cnt_q + WIN_ONE;
        high_cnt_d = high_final;
        if (!en_i || win_end) begin
            win_cnt_d  = '0;
            high_cnt_d = '0;
        end
    end

    // Window result: duty, stall run length and hysteresis comparisons (9-bit, no wrap).
    always_comb begin
        duty_new   = sat_duty(high_final);
        duty_same  = (duty_new == duty_q);
        same_cnt_d = same_cnt_q;
        if (!en_i) begin
            same_cnt_d = 8'd0;
        end else if (win_end) begin
            same_cnt_d = duty_same ? sat_inc8(same_cnt_q) : 8'd0;
        end
        stall_hit = win_end && (same_cnt_d >= STALL_TH);
        rise      = ({1'b0, duty_new}) >= ({1'b0, ext_q} + HYST9);
        fall      = ({1'b0, duty_new} + HYST9) <= ({1'b0, ext_q});
    end

    // Breathe state machine and registered outputs, evaluated once per window.
    always_comb begin
        state_d        = state_q;
        ext_d          = ext_q;
        first_d        = first_q;
        duty_d         = duty_q;
        duty_valid_d   = 1'b0;
        stalled_d      = stalled_q;
        breath_pulse_d = 1'b0;
        breath_cnt_d   = breath_cnt_q;
        if (!en_i) begin
            state_d = ST_IDLE;
            first_d = 1'b0;
        end else if (win_end) begin
            duty_d       = duty_new;
            duty_valid_d = 1'b1;
            if (stall_hit) begin
                // Stall wins over any reversal in the same window.
                stalled_d = 1'b1;
                state_d   = ST_IDLE;
                ext_d     = duty_new;
                first_d   = 1'b1;
            end else begin
                if (!duty_same) begin
                    stalled_d = 1'b0;
                end
                if (!first_q) begin
                    first_d = 1'b1;
                    ext_d   = duty_new;
                    state_d = ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (rise) begin
                                state_d = ST_INHALE;
                                ext_d   = duty_new;
                            end else if (fall) begin
                                state_d = ST_EXHALE;
                                ext_d   = duty_new;
                            end
                        end
                        ST_INHALE: begin
                            if (duty_new > ext_q) begin
                                ext_d = duty_new;
                            end
                            if (fall) begin
                                state_d = ST_EXHALE;
                                ext_d   = duty_new;
                            end
                        end
                        ST_EXHALE: begin
                            if (duty_new < ext_q) begin
                                ext_d = duty_new;
                            end
                            if (rise) begin
                                state_d        = ST_INHALE;
                                ext_d          = duty_new;
                                breath_cnt_d   = breath_cnt_q + 16'd1;
                                breath_pulse_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge Sys_Clk0 or posedge Sys_Clk0_Rst) begin
        if (Sys_Clk0_Rst) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            win_cnt_q      <= '0;
            high_cnt_q     <= '0;
            same_cnt_q     <= 8'd0;
            ext_q          <= 8'd0;
            first_q        <= 1'b0;
            state_q        <= ST_IDLE;
            duty_q         <= 8'd0;
            duty_valid_q   <= 1'b0;
            stalled_q      <= 1'b0;
            breath_pulse_q <= 1'b0;
            breath_cnt_q   <= 16'd0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            win_cnt_q      <= win_cnt_d;
            high_cnt_q     <= high_cnt_d;
            same_cnt_q     <= same_cnt_d;
            ext_q          <= ext_d;
            first_q        <= first_d;
            state_q        <= state_d;
            duty_q         <= duty_d;
            duty_valid_q   <= duty_valid_d;
            stalled_q      <= stalled_d;
            breath_pulse_q <= breath_pulse_d;
            breath_cnt_q   <= breath_cnt_d;
        end
    end

    assign duty_o         = duty_q;
    assign duty_valid_o   = duty_valid_q;
    assign inhale_o       = (state_q == ST_INHALE);
    assign exhale_o       = (state_q == ST_EXHALE);
    assign stalled_o      = stalled_q;
    assign breath_pulse_o = breath_pulse_q;
    assign breath_cnt_o   = breath_cnt_q;

endmodule

// File: tb/tb_pwm_breathe_monitor.sv
// Directed bench for pwm_breathe_monitor with FRAME_BITS=8, HYST=2, STALL_FRAMES=4.
module tb_pwm_breathe_monitor;

    logic        Sys_Clk0;
    logic        Sys_Clk0_Rst;
    logic        en_i;
    logic        pwm_i;
    logic [7:0]  duty_o;
    logic        duty_valid_o;
    logic        inhale_o;
    logic        exhale_o;
    logic        stalled_o;
    logic        breath_pulse_o;
    logic [15:0] breath_cnt_o;

    int checks = 0;
    int errors = 0;

    pwm_breathe_monitor #(
        .FRAME_BITS  (8),
        .HYST        (2),
        .STALL_FRAMES(4)
    ) dut (
        .Sys_Clk0      (Sys_Clk0),
        .Sys_Clk0_Rst  (Sys_Clk0_Rst),
        .en_i          (en_i),
        .pwm_i         (pwm_i),
        .duty_o        (duty_o),
        .duty_valid_o  (duty_valid_o),
        .inhale_o      (inhale_o),
        .exhale_o      (exhale_o),
        .stalled_o     (stalled_o),
        .breath_pulse_o(breath_pulse_o),
        .breath_cnt_o  (breath_cnt_o)
    );

    initial Sys_Clk0 = 1'b0;
    always #5 Sys_Clk0 = ~Sys_Clk0;

    // One aligned 256-cycle window: high for the first d cycles.
    task automatic run_window(input int d);
        for (int k = 0; k < 256; k++) begin
            pwm_i = (k < d);
            @(posedge Sys_Clk0);
            #1;
        end
    endtask

    // Drop enable for a few cycles with the line parked, then start a fresh window.
    task automatic restart(input logic lvl);
        en_i  = 1'b0;
        pwm_i = lvl;
        repeat (4) @(posedge Sys_Clk0);
        #1;
        en_i = 1'b1;
    endtask

    task automatic test_reset;
        Sys_Clk0_Rst = 1'b1;
        en_i         = 1'b0;
        pwm_i        = 1'b0;
        repeat (3) @(posedge Sys_Clk0);
        #1;
        checks++;
        if ({duty_o, duty_valid_o, inhale_o, exhale_o, stalled_o, breath_pulse_o, breath_cnt_o} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got duty=%0d dv=%b inh=%b exh=%b stall=%b bp=%b cnt=%0d required all 0",
                     duty_o, duty_valid_o, inhale_o, exhale_o, stalled_o, breath_pulse_o, breath_cnt_o);
        end
        Sys_Clk0_Rst = 1'b0;
        @(posedge Sys_Clk0);
        #1;
    endtask

    task automatic test_constant_high;
        restart(1'b1);
        for (int w = 1; w <= 5; w++) begin
            run_window(256);
            checks++;
            if (duty_valid_o !== 1'b1 || duty_o !== 8'd255) begin
                errors++;
                $display("FAIL const_duty w%0d: got dv=%b duty=%0d required dv=1 duty=255", w, duty_valid_o, duty_o);
            end
            checks++;
            if (stalled_o !== (w >= 4)) begin
                errors++;
                $display("FAIL const_stall w%0d: got %b required %b", w, stalled_o, (w >= 4));
            end
            checks++;
            if (inhale_o !== 1'b0 || exhale_o !== 1'b0) begin
                errors++;
                $display("FAIL const_state w%0d: got inh=%b exh=%b required 0 0", w, inhale_o, exhale_o);
            end
        end
        @(posedge Sys_Clk0);
        #1;
        checks++;
        if (duty_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL dv_one_cycle: got %b required 0", duty_valid_o);
        end
    endtask

    task automatic test_square;
        restart(1'b0);
        checks++;
        if (stalled_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_held_disabled: got %b required 1", stalled_o);
        end
        run_window(64);
        checks++;
        if (duty_valid_o !== 1'b1 || duty_o < 8'd63 || duty_o > 8'd65) begin
            errors++;
            $display("FAIL square_64: got dv=%b duty=%0d required dv=1 duty 63..65", duty_valid_o, duty_o);
        end
        checks++;
        if (stalled_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got %b required 0", stalled_o);
        end
        run_window(64);
        checks++;
        if (duty_o !== 8'd64) begin
            errors++;
            $display("FAIL square_64_again: got %0d required 64", duty_o);
        end
        // Two low samples from the previous window's tail spill into this one.
        run_window(256);
        checks++;
        if (duty_o !== 8'd254) begin
            errors++;
            $display("FAIL near_full: got %0d required 254", duty_o);
        end
        run_window(256);
        checks++;
        if (duty_o !== 8'd255) begin
            errors++;
            $display("FAIL full_saturate: got %0d required 255", duty_o);
        end
    endtask

    task automatic test_breathe_ramp;
        int seq[$];
        int pulses;
        logic exp_inh, exp_exh, exp_bp;
        pulses = 0;
        for (int i = 1; i <= 20; i++) seq.push_back(10 * i);
        for (int i = 19; i >= 1; i--) seq.push_back(10 * i);
        seq.push_back(20);
        seq.push_back(30);
        restart(1'b0);
        for (int n = 0; n < seq.size(); n++) begin
            run_window(seq[n]);
            exp_inh = (n >= 1 && n <= 19) || (n >= 39);
            exp_exh = (n >= 20 && n <= 38);
            exp_bp  = (n == 39);
            if (breath_pulse_o === 1'b1) pulses++;
            checks++;
            if (duty_o !== 8'(seq[n]) || inhale_o !== exp_inh || exhale_o !== exp_exh || breath_pulse_o !== exp_bp) begin
                errors++;
                $display("FAIL ramp w%0d: got duty=%0d inh=%b exh=%b bp=%b required duty=%0d inh=%b exh=%b bp=%b",
                         n, duty_o, inhale_o, exhale_o, breath_pulse_o, seq[n], exp_inh, exp_exh, exp_bp);
            end
        end
        checks++;
        if (breath_cnt_o !== 16'd1 || pulses != 1) begin
            errors++;
            $display("FAIL ramp_count: got cnt=%0d pulses=%0d required 1 1", breath_cnt_o, pulses);
        end
    endtask

    task automatic test_enable_gating;
        int  bad;
        int  n;
        bit  seen;
        bad   = 0;
        pwm_i = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge Sys_Clk0);
            #1;
            if (duty_valid_o !== 1'b0) bad++;
        end
        en_i = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge Sys_Clk0);
            #1;
            if (duty_valid_o !== 1'b0 || breath_pulse_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gate_no_pulse: got %0d stray pulses required 0", bad);
        end
        checks++;
        if (breath_cnt_o !== 16'd1 || inhale_o !== 1'b0 || exhale_o !== 1'b0) begin
            errors++;
            $display("FAIL gate_hold: got cnt=%0d inh=%b exh=%b required 1 0 0", breath_cnt_o, inhale_o, exhale_o);
        end
        en_i = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(posedge Sys_Clk0);
            #1;
            n++;
            if (duty_valid_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 256) begin
            errors++;
            $display("FAIL gate_reenable_latency: got seen=%b cycles=%0d required 256", seen, n);
        end
        checks++;
        if (breath_cnt_o !== 16'd1 || inhale_o !== 1'b0 || exhale_o !== 1'b0 || duty_o !== 8'd0) begin
            errors++;
            $display("FAIL gate_after: got cnt=%0d inh=%b exh=%b duty=%0d required 1 0 0 0",
                     breath_cnt_o, inhale_o, exhale_o, duty_o);
        end
    endtask

    task automatic test_hysteresis;
        int bad;
        bad = 0;
        restart(1'b0);
        for (int n = 0; n < 6; n++) begin
            run_window((n % 2 == 0) ? 100 : 101);
            if (inhale_o !== 1'b0 || exhale_o !== 1'b0 || breath_pulse_o !== 1'b0) bad++;
        end
        run_window(100);
        if (inhale_o !== 1'b0 || exhale_o !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hyst_hold: got %0d state changes required 0", bad);
        end
        run_window(102);
        checks++;
        if (inhale_o !== 1'b1 || exhale_o !== 1'b0 || breath_pulse_o !== 1'b0) begin
            errors++;
            $display("FAIL hyst_inhale: got inh=%b exh=%b bp=%b required 1 0 0", inhale_o, exhale_o, breath_pulse_o);
        end
    endtask

    task automatic test_reset_mid;
        int  n;
        bit  seen;
        for (int b = 0; b < 4; b++) begin
            run_window(10);
            run_window(20);
            checks++;
            if (breath_pulse_o !== 1'b1 || breath_cnt_o !== 16'(b + 2)) begin
                errors++;
                $display("FAIL breath_%0d: got bp=%b cnt=%0d required 1 %0d", b, breath_pulse_o, breath_cnt_o, b + 2);
            end
        end
        run_window(10);
        checks++;
        if (breath_cnt_o !== 16'd5 || exhale_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got cnt=%0d exh=%b required 5 1", breath_cnt_o, exhale_o);
        end
        pwm_i = 1'b0;
        repeat (130) @(posedge Sys_Clk0);
        #1;
        Sys_Clk0_Rst = 1'b1;
        #1;
        checks++;
        if ({duty_o, duty_valid_o, inhale_o, exhale_o, stalled_o, breath_pulse_o, breath_cnt_o} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset: got duty=%0d inh=%b exh=%b stall=%b cnt=%0d required all 0",
                     duty_o, inhale_o, exhale_o, stalled_o, breath_cnt_o);
        end
        @(posedge Sys_Clk0);
        #1;
        Sys_Clk0_Rst = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(posedge Sys_Clk0);
            #1;
            n++;
            if (duty_valid_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 256) begin
            errors++;
            $display("FAIL reset_release_latency: got seen=%b cycles=%0d required 256", seen, n);
        end
        checks++;
        if (duty_o !== 8'd0 || breath_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_window: got duty=%0d cnt=%0d required 0 0", duty_o, breath_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_constant_high();
        test_square();
        test_breathe_ramp();
        test_enable_gating();
        test_hysteresis();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
